// File: rtl/mem_port_arbiter.sv
// Two-master round-robin arbiter in front of a single-port memory macro.
// Each access runs to completion: a write takes one cycle; a read holds the address for RD_LAT edges.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 16,
  parameter int RD_LAT     = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  m0_req,
  input  logic                  m0_we,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  output logic                  m0_gnt,
  output logic                  m0_done,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  input  logic                  m1_req,
  input  logic                  m1_we,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  output logic                  m1_gnt,
  output logic                  m1_done,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  busy
);

  localparam logic [3:0] LAT = 4'(RD_LAT);

  typedef enum logic [1:0] {IDLE, WRITE, READ} state_e;

  typedef struct packed {
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
  } acc_t;

  state_e                       state_q, state_d;
  logic                         last_q, last_d;
  logic                         owner_q, owner_d;
  logic [3:0]                   cnt_q, cnt_d;
  acc_t                         acc_q, acc_d;
  logic [1:0]                   done_q, done_d;
  logic [1:0][DATA_WIDTH-1:0]   rdata_q, rdata_d;

  logic [1:0] req;
  logic [1:0] gnt;
  logic       sel;
  acc_t [1:0] in_acc;

  assign req       = {m1_req, m0_req};
  assign in_acc[0] = {m0_we, m0_addr, m0_wdata};
  assign in_acc[1] = {m1_we, m1_addr, m1_wdata};

  // A lone requester always wins; on a tie the port not served last wins.
  always_comb begin
    gnt = 2'b00;
    sel = 1'b0;
    if (state_q == IDLE) begin
      sel = (req == 2'b11) ? ~last_q : req[1];
      if (|req) gnt = sel ? 2'b10 : 2'b01;
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    done_d  = 2'b00;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (|req) begin
          owner_d = sel;
          last_d  = sel;
          acc_d   = in_acc[sel];
          cnt_d   = 4'd1;
          state_d = in_acc[sel].we ? WRITE : READ;
        end
      end
      WRITE: begin
        done_d[owner_q] = 1'b1;
        state_d         = IDLE;
      end
      READ: begin
        if (cnt_q == LAT) begin
          rdata_d[owner_q] = mem_rdata;
          done_d[owner_q]  = 1'b1;
          state_d          = IDLE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      owner_q <= 1'b0;
      cnt_q   <= '0;
      acc_q   <= '0;
      done_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      done_q  <= done_d;
      rdata_q <= rdata_d;
    end
  end

  assign m0_gnt    = gnt[0];
  assign m1_gnt    = gnt[1];
  assign m0_done   = done_q[0];
  assign m1_done   = done_q[1];
  assign m0_rdata  = rdata_q[0];
  assign m1_rdata  = rdata_q[1];
  // mem_we follows the state so it drops the instant reset asserts.
  assign mem_we    = (state_q == WRITE);
  assign mem_addr  = acc_q.addr;
  assign mem_wdata = acc_q.wdata;
  assign busy      = (state_q != IDLE);

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port data/program memory between two bus masters (port 0: CPU, port 1: loader/debug/DMA engine).
- Arbitrates round-robin and sequences each access, including the fixed read latency: address is held stable for RD_LAT cycles, then read data is captured.
- Sits between the requesters and the memory macro and drives its we/addr/data pins.

Parameters:
- ADDR_WIDTH, 6, memory address width.
- DATA_WIDTH, 16, memory word width.
- RD_LAT, 2, number of clock edges between the first cycle mem_addr is presented and the edge that samples mem_rdata. Legal range is 1..15.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- m0_req  in  1  port 0 access request; held until granted.
- m0_we  in  1  port 0: 1 = write, 0 = read.
- m0_addr  in  ADDR_WIDTH  port 0 address.
- m0_wdata  in  DATA_WIDTH  port 0 write data.
- m0_gnt  out  1  port 0 request accepted this cycle (combinational).
- m0_done  out  1  one-cycle pulse: port 0 access complete.
- m0_rdata  out  DATA_WIDTH  port 0 read data, valid when m0_done=1.
- m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_done, m1_rdata: same as port 0, for port 1.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_WIDTH  memory address.
- mem_wdata  out  DATA_WIDTH  memory write data.
- mem_rdata  in  DATA_WIDTH  memory read data.
- busy  out  1  high when the FSM is not in IDLE.

Behaviour:
- Reset (async, immediate):
  - FSM goes to IDLE; last-grant pointer = 1, so port 0 wins the first tie.
  - Latch counter = 0.
  - mem_we, mem_addr, mem_wdata, both done, both rdata, and busy are all 0.
- FSM states: IDLE, WRITE, READ.
- IDLE:
  - gnt is combinational, asserted only in IDLE and only to a requesting port.
  - Single requester: that port is granted, regardless of the pointer.
  - Both requesting: the port not granted last is granted.
  - On the edge with gnt: latch owner, we, addr, wdata; update the pointer to the owner; next state is WRITE if we=1, else READ with cnt=1.
  - With no request, stay in IDLE; mem_addr and mem_wdata hold their last latched values; mem_we=0.
- WRITE (exactly 1 cycle):
  - mem_we=1, with latched addr and wdata on the memory pins.
  - Next edge: go to IDLE and pulse owner done=1 for the following cycle. rdata is unchanged.
- READ:
  - mem_we=0, latched address held.
  - At the edge where cnt==RD_LAT: owner rdata <= mem_rdata, owner done <= 1, go to IDLE. Otherwise cnt++.
- Latency, measured from the grant cycle (cycle 0):
  - Write: mem_we in cycle 1, done in cycle 2.
  - Read: address in cycles 1..RD_LAT, done plus rdata in cycle RD_LAT+1.
- done is registered and high for exactly one cycle. rdata holds until that port's next read completes.
- The done cycle is an IDLE cycle, so a new grant may occur in the same cycle as a done. Back-to-back read period is RD_LAT+1 cycles.
- The non-owner port sees no done and no rdata change.
- req/we/addr/wdata are sampled only on the grant edge; changes during an access are ignored.
- A request dropped before grant is silently abandoned.
- Only one access is in flight at a time; no queuing.
- Reset asserted mid-access aborts the access: no done pulse, and mem_we falls immediately. After release, the next request is served normally.
- Continuous dual requests alternate 0,1,0,1,…; neither port is ever granted twice consecutively while the other requests.

Test Plan:
1. Reset, then m0 read addr 5 with mem[5]=0x1234, RD_LAT=2 → m0_gnt in cycle 0; mem_addr=5 and busy=1 in cycles 1–2; m0_done=1 and m0_rdata=0x1234 in cycle 3; m1_done stays 0.
2. m1 write addr 0x3F, data 0xBEEF → mem_we=1 in cycle 1 only, with mem_addr=0x3F and mem_wdata=0xBEEF; m1_done in cycle 2; m1_rdata unchanged.
3. Both ports request reads continuously after reset → grant order m0,m1,m0,m1; grants in cycles 0,3,6,9; each done carries its own port's address data.
4. Only m1 requests, twice in succession → both granted, with no wait for port 0.
5. rst_n pulsed low in cycle 1 of an m0 read → busy, mem_we, and done drop to 0 immediately; no m0_done ever appears; a subsequent m1 read completes normally with m1 granted first.
6. RD_LAT=3, m0 read addr 2 with mem[2]=0x00A5 → mem_addr=2 in cycles 1–3; m0_done and m0_rdata=0x00A5 in cycle 4.
